// File: rtl/sobel_pkg.sv
// Shared types and defaults for the Sobel line-buffer controller.
package sobel_pkg;

  localparam int PIX_W_DEF  = 8;
  localparam int IMG_W_DEF  = 640;
  localparam int IMG_H_DEF  = 480;
  localparam int ADDR_W_DEF = 10;

  // Row counter width; a single-line image still needs a 1-bit port.
  function automatic int row_w(input int h);
    return (h > 1) ? $clog2(h) : 1;
  endfunction

  localparam int ROW_W_DEF = row_w(IMG_H_DEF);

  typedef struct packed {
    logic eol;
    logic eof;
    logic win_ok;
  } pos_flags_t;

  typedef struct packed {
    logic [PIX_W_DEF-1:0]  top;
    logic [PIX_W_DEF-1:0]  mid;
    logic [PIX_W_DEF-1:0]  bot;
    logic [ADDR_W_DEF-1:0] col;
    logic [ROW_W_DEF-1:0]  row;
    pos_flags_t            flags;
  } col_out_t;

endpackage

// File: rtl/sobel_pos_cnt.sv
// Raster position counter: column/row wrap, start-of-frame resync and
// per-pixel eol/eof/window flags for the pixel currently being offered.
module sobel_pos_cnt
  import sobel_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ROW_W  = row_w(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_fire,
  input  logic              i_sof,
  output logic [ADDR_W-1:0] o_col,
  output logic [ROW_W-1:0]  o_row,
  output pos_flags_t        o_flags,
  output logic              o_sync_err
);

  localparam logic [ADDR_W-1:0] LAST_COL = ADDR_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(IMG_H - 1);

  logic [ADDR_W-1:0] r_col;
  logic [ROW_W-1:0]  r_row;
  logic              w_last_col;
  logic              w_last_row;

  // A start-of-frame pixel is always placed at the origin, whatever the counters say.
  always_comb begin
    o_col          = i_sof ? '0 : r_col;
    o_row          = i_sof ? '0 : r_row;
    w_last_col     = (o_col == LAST_COL);
    w_last_row     = (o_row == LAST_ROW);
    o_flags.eol    = w_last_col;
    o_flags.eof    = w_last_col && w_last_row;
    o_flags.win_ok = (int'(o_row) >= 2) && (int'(o_col) >= 2);
    o_sync_err     = i_fire && i_sof && ((r_col != '0) || (r_row != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (i_fire) begin
      if (w_last_col) begin
        r_col <= '0;
        r_row <= w_last_row ? '0 : o_row + 1'b1;
      end else begin
        r_col <= o_col + 1'b1;
        r_row <= o_row;
      end
    end
  end

endmodule

// File: rtl/sobel_linebuf_ctrl.sv
// Two-line cascade buffer controller: drives two external read-first line RAMs
// and emits one 3-pixel vertical column (rows y-2, y-1, y) per accepted pixel.
module sobel_linebuf_ctrl
  import sobel_pkg::*;
#(
  parameter int PIX_W  = PIX_W_DEF,
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int ROW_W  = row_w(IMG_H)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [PIX_W-1:0]  s_data,
  input  logic              s_sof,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [PIX_W-1:0]  m_top,
  output logic [PIX_W-1:0]  m_mid,
  output logic [PIX_W-1:0]  m_bot,
  output logic [ADDR_W-1:0] m_col,
  output logic [ROW_W-1:0]  m_row,
  output logic              m_win_ok,
  output logic              m_eol,
  output logic              m_eof,
  output logic              sync_err,
  output logic              r0_we,
  output logic [ADDR_W-1:0] r0_wr_addr,
  output logic [PIX_W-1:0]  r0_wr_data,
  output logic [ADDR_W-1:0] r0_rd_addr,
  input  logic [PIX_W-1:0]  r0_rd_data,
  output logic              r1_we,
  output logic [ADDR_W-1:0] r1_wr_addr,
  output logic [PIX_W-1:0]  r1_wr_data,
  output logic [ADDR_W-1:0] r1_rd_addr,
  input  logic [PIX_W-1:0]  r1_rd_data
);

  logic              w_en;
  logic              w_fire;
  logic              w_adv;
  logic [ADDR_W-1:0] w_col;
  logic [ROW_W-1:0]  w_row;
  pos_flags_t        w_flags;

  logic              r_v1;
  logic [PIX_W-1:0]  r_s1_pix;
  logic [ADDR_W-1:0] r_s1_col;
  logic [ROW_W-1:0]  r_s1_row;
  pos_flags_t        r_s1_flags;

  logic              r_m_valid;
  logic [PIX_W-1:0]  r_m_top;
  logic [PIX_W-1:0]  r_m_mid;
  logic [PIX_W-1:0]  r_m_bot;
  logic [ADDR_W-1:0] r_m_col;
  logic [ROW_W-1:0]  r_m_row;
  pos_flags_t        r_m_flags;

  sobel_pos_cnt #(
    .IMG_W  (IMG_W),
    .IMG_H  (IMG_H),
    .ADDR_W (ADDR_W),
    .ROW_W  (ROW_W)
  ) u_pos (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_fire     (w_fire),
    .i_sof      (s_sof),
    .o_col      (w_col),
    .o_row      (w_row),
    .o_flags    (w_flags),
    .o_sync_err (sync_err)
  );

  assign w_en    = !r_m_valid || m_ready;
  assign w_fire  = s_valid && w_en;
  assign w_adv   = w_en && r_v1;
  assign s_ready = w_en;

  // While stalled the stage-1 column is re-read so the RAM outputs stay put.
  assign r0_rd_addr = w_fire ? w_col : r_s1_col;
  assign r1_rd_addr = r0_rd_addr;

  // Cascade on advance: new pixel into RAM 0, the row it displaces into RAM 1.
  assign r0_we      = w_adv;
  assign r0_wr_addr = r_s1_col;
  assign r0_wr_data = r_s1_pix;
  assign r1_we      = w_adv;
  assign r1_wr_addr = r_s1_col;
  assign r1_wr_data = r0_rd_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1       <= 1'b0;
      r_s1_pix   <= '0;
      r_s1_col   <= '0;
      r_s1_row   <= '0;
      r_s1_flags <= '0;
    end else if (w_en) begin
      r_v1 <= s_valid;
      if (w_fire) begin
        r_s1_pix   <= s_data;
        r_s1_col   <= w_col;
        r_s1_row   <= w_row;
        r_s1_flags <= w_flags;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_top   <= '0;
      r_m_mid   <= '0;
      r_m_bot   <= '0;
      r_m_col   <= '0;
      r_m_row   <= '0;
      r_m_flags <= '0;
    end else if (w_en) begin
      r_m_valid <= r_v1;
      if (r_v1) begin
        r_m_top   <= r1_rd_data;
        r_m_mid   <= r0_rd_data;
        r_m_bot   <= r_s1_pix;
        r_m_col   <= r_s1_col;
        r_m_row   <= r_s1_row;
        r_m_flags <= r_s1_flags;
      end
    end
  end

  assign m_valid  = r_m_valid;
  assign m_top    = r_m_top;
  assign m_mid    = r_m_mid;
  assign m_bot    = r_m_bot;
  assign m_col    = r_m_col;
  assign m_row    = r_m_row;
  assign m_win_ok = r_m_flags.win_ok;
  assign m_eol    = r_m_flags.eol;
  assign m_eof    = r_m_flags.eof;

endmodule

// File: tb/tb_sobel_linebuf_ctrl.sv
// Bench for sobel_linebuf_ctrl on a 4x4 image: directed frames, stall, resync,
// mid-frame reset and random traffic against a per-column pixel-history model.
module tb_sobel_linebuf_ctrl;

  localparam int PIX_W  = 8;
  localparam int IMG_W  = 4;
  localparam int IMG_H  = 4;
  localparam int ADDR_W = 2;
  localparam int ROW_W  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              s_valid, s_ready, s_sof;
  logic [PIX_W-1:0]  s_data;
  logic              m_valid, m_ready;
  logic [PIX_W-1:0]  m_top, m_mid, m_bot;
  logic [ADDR_W-1:0] m_col;
  logic [ROW_W-1:0]  m_row;
  logic              m_win_ok, m_eol, m_eof, sync_err;
  logic              r0_we, r1_we;
  logic [ADDR_W-1:0] r0_wr_addr, r0_rd_addr, r1_wr_addr, r1_rd_addr;
  logic [PIX_W-1:0]  r0_wr_data, r0_rd_data, r1_wr_data, r1_rd_data;

  sobel_linebuf_ctrl #(
    .PIX_W(PIX_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .ROW_W(ROW_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_top(m_top), .m_mid(m_mid), .m_bot(m_bot),
    .m_col(m_col), .m_row(m_row),
    .m_win_ok(m_win_ok), .m_eol(m_eol), .m_eof(m_eof), .sync_err(sync_err),
    .r0_we(r0_we), .r0_wr_addr(r0_wr_addr), .r0_wr_data(r0_wr_data),
    .r0_rd_addr(r0_rd_addr), .r0_rd_data(r0_rd_data),
    .r1_we(r1_we), .r1_wr_addr(r1_wr_addr), .r1_wr_data(r1_wr_data),
    .r1_rd_addr(r1_rd_addr), .r1_rd_data(r1_rd_data)
  );

  always #5 clk = ~clk;

  // Read-first line RAMs owned by the parent; cleared while reset is held.
  logic [PIX_W-1:0] ram0 [IMG_W];
  logic [PIX_W-1:0] ram1 [IMG_W];
  always @(posedge clk) begin
    r0_rd_data <= ram0[r0_rd_addr];
    r1_rd_data <= ram1[r1_rd_addr];
    if (!rst_n) begin
      for (int i = 0; i < IMG_W; i++) begin
        ram0[i] <= '0;
        ram1[i] <= '0;
      end
    end else begin
      if (r0_we) ram0[r0_wr_addr] <= r0_wr_data;
      if (r1_we) ram1[r1_wr_addr] <= r1_wr_data;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int stall_until = 0;
  bit rand_rdy    = 1'b0;
  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (cyc_cnt < stall_until) m_ready = 1'b0;
      else if (rand_rdy)         m_ready = ($urandom_range(0, 9) < 7);
      else                       m_ready = 1'b1;
    end
  end

  // Reference model: each column remembers the last two pixels that passed it.
  typedef struct {
    logic [PIX_W-1:0] t, m, b;
    int               col, row;
    logic             win, eol, eof;
  } exp_t;

  exp_t             q[$];
  logic [PIX_W-1:0] h1 [IMG_W];
  logic [PIX_W-1:0] h2 [IMG_W];
  int               mx, my;
  bit               lat_arm = 1'b0, lat_done = 1'b0;
  int               first_acc = -1;
  bit               rand_phase = 1'b0;
  int               rnd_cols = 0, frames = 0;
  bit               held_v;
  logic [31:0]      held, cur;

  always @(negedge clk) begin
    exp_t e;
    logic exp_err;
    if (!rst_n) begin
      q.delete();
      held_v = 1'b0;
      mx = 0;
      my = 0;
      for (int i = 0; i < IMG_W; i++) begin
        h1[i] = '0;
        h2[i] = '0;
      end
    end else begin
      if (lat_arm && !lat_done && first_acc >= 0 && m_valid) begin
        check("latency", 32'(cyc_cnt - first_acc), 32'd2);
        lat_done = 1'b1;
      end
      cur = {1'b0, m_top, m_mid, m_bot, m_col, m_row, m_win_ok, m_eol, m_eof};
      if (held_v) check("hold", cur, held);
      held_v = m_valid && !m_ready;
      held   = cur;
      if (held_v) check("s_ready_stall", 32'(s_ready), 32'd0);
      if (m_valid && m_ready) begin
        if (q.size() == 0) begin
          check("underflow", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          $display("col x=%0d y=%0d top=%0d mid=%0d bot=%0d win=%0b eol=%0b eof=%0b",
                   m_col, m_row, m_top, m_mid, m_bot, m_win_ok, m_eol, m_eof);
          check("top",    32'(m_top),    32'(e.t));
          check("mid",    32'(m_mid),    32'(e.m));
          check("bot",    32'(m_bot),    32'(e.b));
          check("col",    32'(m_col),    32'(e.col));
          check("row",    32'(m_row),    32'(e.row));
          check("win_ok", 32'(m_win_ok), 32'(e.win));
          check("eol",    32'(m_eol),    32'(e.eol));
          check("eof",    32'(m_eof),    32'(e.eof));
          if (rand_phase) begin
            rnd_cols++;
            if (e.eof) begin
              check("frame_cols", 32'(rnd_cols), 32'd16);
              rnd_cols = 0;
              frames++;
            end
          end
        end
      end
      if (s_valid && s_ready) begin
        if (lat_arm && first_acc < 0) first_acc = cyc_cnt;
        exp_err = 1'b0;
        if (s_sof) begin
          exp_err = (mx != 0) || (my != 0);
          mx = 0;
          my = 0;
        end
        e.t   = h2[mx];
        e.m   = h1[mx];
        e.b   = s_data;
        e.col = mx;
        e.row = my;
        e.win = (mx >= 2) && (my >= 2);
        e.eol = (mx == IMG_W - 1);
        e.eof = (mx == IMG_W - 1) && (my == IMG_H - 1);
        h2[mx] = h1[mx];
        h1[mx] = s_data;
        q.push_back(e);
        check("sync_err", 32'(sync_err), 32'(exp_err));
        mx++;
        if (mx == IMG_W) begin
          mx = 0;
          my = (my == IMG_H - 1) ? 0 : my + 1;
        end
      end else begin
        check("sync_err_idle", 32'(sync_err), 32'd0);
      end
    end
  end

  task automatic send(input logic [PIX_W-1:0] d, input logic sof);
    int guard = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    @(negedge clk);
    while (!s_ready && guard < 200) begin
      guard++;
      @(negedge clk);
    end
    if (guard >= 200) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q.size() != 0 || m_valid) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) check("drain_timeout", 32'd1, 32'd0);
  endtask

  task automatic frame_seq(input int first, input int last, input int sof_at);
    for (int p = first; p <= last; p++) send(8'(p), p == sof_at);
  endtask

  initial begin
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_sof   = 1'b0;
    s_data  = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_s_ready", 32'(s_ready), 32'd1);
    check("rst_we",      32'({r0_we, r1_we}), 32'd0);
    check("rst_data",    32'({m_top, m_mid, m_bot, m_col, m_row}), 32'd0);
    @(posedge clk); #1;

    // Frame 0: continuous flow, latency check on the first pixel.
    lat_arm = 1'b1;
    frame_seq(0, 15, 0);
    drain(20);

    // Frame 1: same data, downstream stall of at least 5 cycles in row 2.
    frame_seq(0, 9, 0);
    stall_until = cyc_cnt + 6;
    frame_seq(10, 15, -1);
    drain(30);

    // Frame 2: resync on pixel 6.
    frame_seq(0, 5, 0);
    send(8'd6, 1'b1);
    frame_seq(7, 15, -1);
    drain(20);

    // Mid-frame reset with both pipeline stages occupied.
    send(8'd100, 1'b1);
    send(8'd101, 1'b0);
    send(8'd102, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_m_valid", 32'(m_valid), 32'd0);
    check("rst_mid_we",      32'({r0_we, r1_we}), 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    frame_seq(16, 31, -1);
    drain(20);

    // Random traffic over three frames.
    rand_phase = 1'b1;
    rand_rdy   = 1'b1;
    for (int f = 0; f < 3; f++) begin
      for (int p = 0; p < IMG_W * IMG_H; p++) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
        send(8'($urandom), p == 0);
      end
    end
    rand_rdy = 1'b0;
    drain(100);
    check("frames", 32'(frames), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
